// File: rtl/data_sram_resp_pkg.sv
// Shared CPU package: data-SRAM byte-enable encodings and access classification.
package data_sram_resp_pkg;

  localparam logic [3:0] WE_NONE = 4'h0;
  localparam logic [3:0] WE_B0   = 4'h1;
  localparam logic [3:0] WE_B1   = 4'h2;
  localparam logic [3:0] WE_B2   = 4'h4;
  localparam logic [3:0] WE_B3   = 4'h8;
  localparam logic [3:0] WE_H0   = 4'h3;
  localparam logic [3:0] WE_H1   = 4'hC;
  localparam logic [3:0] WE_W    = 4'hF;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_WRITE,
    ACC_ILLEGAL
  } acc_kind_e;

  function automatic acc_kind_e classify_access(input logic en, input logic [3:0] we);
    acc_kind_e kind;
    kind = ACC_ILLEGAL;
    if (!en) begin
      kind = ACC_IDLE;
    end else begin
      case (we)
        WE_NONE:                             kind = ACC_READ;
        WE_B0, WE_B1, WE_B2, WE_B3,
        WE_H0, WE_H1, WE_W:                  kind = ACC_WRITE;
        default:                             kind = ACC_ILLEGAL;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/data_sram_resp_sram_byte_lane.sv
// One 8-bit data-SRAM lane: synchronous write, registered read-first output.
module sram_byte_lane #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0] mem [DEPTH];

  // Array content survives reset; only the write is suppressed while in reset.
  always_ff @(posedge clk) begin
    if (resetn && wr_en) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM with byte-lane writes, 1-cycle read-first response, access counters and sticky byte-enable error.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        err_we
);

  acc_kind_e             acc;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  lane_rd;
  logic [3:0]            lane_wr;
  logic                  unused_addr_bits;

  assign word_idx         = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

  always_comb begin
    acc     = classify_access(data_sram_en, data_sram_we);
    lane_rd = (acc == ACC_READ) || (acc == ACC_WRITE);
    lane_wr = (acc == ACC_WRITE) ? data_sram_we : '0;
  end

  // Every lane loads on reads and legal writes, so rdata holds as a whole word otherwise.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    sram_byte_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .rd_en  (lane_rd),
      .wr_en  (lane_wr[i]),
      .addr   (word_idx),
      .wdata  (data_sram_wdata[8*i +: 8]),
      .rdata  (data_sram_rdata[8*i +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_we <= 1'b0;
    end else begin
      if (acc == ACC_READ)    rd_cnt <= rd_cnt + 32'd1;
      if (acc == ACC_WRITE)   wr_cnt <= wr_cnt + 32'd1;
      if (acc == ACC_ILLEGAL) err_we <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: directed scenarios plus random traffic vs. a word-array model.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = '0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        err_we;

  data_sram_resp #(.DEPTH_LOG2(10)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .err_we          (err_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          known;
    logic [31:0] rd;
    logic [31:0] wr;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model: word-indexed memory, counters, sticky error.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] m_rdata = '0;
  bit          m_known = 1'b0;
  logic [31:0] m_rd = '0;
  logic [31:0] m_wr = '0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wd, input string tag);
    exp_t        e;
    int unsigned idx;
    bit          old_known;
    logic [31:0] old;
    logic [31:0] nw;
    resetn          = ~rst;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wd;
    @(posedge clk);
    idx       = (addr >> 2) % 1024;
    old_known = ref_mem.exists(idx);
    old       = old_known ? ref_mem[idx] : 32'hx;
    if (rst) begin
      m_rdata = '0; m_known = 1'b1; m_rd = '0; m_wr = '0; m_err = 1'b0;
    end else if (en) begin
      if (we == 4'h0) begin
        m_rdata = old; m_known = old_known; m_rd = m_rd + 1;
      end else if (we inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}) begin
        m_rdata = old; m_known = old_known; m_wr = m_wr + 1;
        nw = old;
        for (int i = 0; i < 4; i++)
          if (we[i]) nw[8*i +: 8] = wd[8*i +: 8];
        if (old_known || we == 4'hF) ref_mem[idx] = nw;
      end else begin
        m_err = 1'b1;
      end
    end
    e.rdata = m_rdata; e.known = m_known; e.rd = m_rd; e.wr = m_wr; e.err = m_err; e.tag = tag;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.known) check({e.tag, "_rdata"}, data_sram_rdata, e.rdata);
      check({e.tag, "_rd_cnt"}, rd_cnt, e.rd);
      check({e.tag, "_wr_cnt"}, wr_cnt, e.wr);
      check({e.tag, "_err_we"}, {31'd0, err_we}, {31'd0, e.err});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  logic [3:0]  legal_we [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
  logic [3:0]  bad_we   [8] = '{4'h5, 4'h6, 4'h9, 4'hA, 4'h7, 4'hB, 4'hD, 4'hE};

  initial begin
    logic [31:0] a;
    logic [31:0] r;
    int unsigned sel;

    step(1, 0, 4'h0, 32'h0, 32'h0, "reset");
    step(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, "reset_wr");
    check("reset_rdata", data_sram_rdata, 32'h0);

    // Full-word write then read.
    step(0, 1, 4'hF, 32'h10, 32'h1234_5678, "wr10");
    step(0, 1, 4'h0, 32'h10, 32'h0, "rd10");
    check("rd10_const", data_sram_rdata, 32'h1234_5678);
    check("rd10_wr_cnt", wr_cnt, 32'd1);
    check("rd10_rd_cnt", rd_cnt, 32'd1);

    // Upper halfword write.
    step(0, 1, 4'hC, 32'h12, 32'hABCD_ABCD, "wr12_hw");
    check("wr12_readfirst", data_sram_rdata, 32'h1234_5678);
    step(0, 1, 4'h0, 32'h10, 32'h0, "rd10_hw");
    check("rd10_hw_const", data_sram_rdata, 32'hABCD_5678);

    // Illegal byte-enable: no write, rdata holds, sticky error.
    step(0, 1, 4'h5, 32'h10, 32'h5555_5555, "illegal");
    check("illegal_hold", data_sram_rdata, 32'hABCD_5678);
    check("illegal_err", {31'd0, err_we}, 32'd1);
    check("illegal_wr_cnt", wr_cnt, 32'd2);
    step(0, 1, 4'h0, 32'h10, 32'h0, "rd_after_illegal");
    check("rd_after_illegal_const", data_sram_rdata, 32'hABCD_5678);

    // Single byte write to lane 3.
    step(0, 1, 4'h8, 32'h13, 32'hEEEE_EEEE, "wr13_b");
    step(0, 1, 4'h0, 32'h10, 32'h0, "rd10_b");
    check("rd10_b_const", data_sram_rdata, 32'hEECD_5678);

    // Back-to-back writes: read-first then no stale data.
    step(0, 1, 4'hF, 32'h20, 32'h1, "wr20_a");
    step(0, 1, 4'hF, 32'h20, 32'h2, "wr20_b");
    check("wr20_readfirst", data_sram_rdata, 32'h1);
    step(0, 1, 4'h0, 32'h20, 32'h0, "rd20");
    check("rd20_const", data_sram_rdata, 32'h2);

    // Aliasing modulo 4 KiB, then idle cycles with toggling inputs.
    step(0, 1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D, "wr_alias");
    step(0, 1, 4'h0, 32'h0000_0004, 32'h0, "rd_alias");
    check("rd_alias_const", data_sram_rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      step(0, 0, 4'(i + 3), a, ~a, "idle");
    end
    check("idle_rdata", data_sram_rdata, 32'hCAFE_F00D);
    check("idle_err", {31'd0, err_we}, 32'd1);

    // Reset the cycle after a read request.
    step(0, 1, 4'h0, 32'h10, 32'h0, "rd_pre_rst");
    step(1, 1, 4'h0, 32'h10, 32'h0, "rst_after_rd");
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);
    check("rst_err", {31'd0, err_we}, 32'd0);
    step(0, 1, 4'h0, 32'h10, 32'h0, "rd_post_rst");
    check("rd_post_rst_const", data_sram_rdata, 32'hEECD_5678);
    step(0, 1, 4'h0, 32'h4, 32'h0, "rd_post_rst2");
    check("rd_post_rst2_const", data_sram_rdata, 32'hCAFE_F00D);

    // Random traffic over a 16-word pool with aliased upper/low address bits.
    for (int i = 0; i < 16; i++)
      step(0, 1, 4'hF, 32'(('h40 + i) << 2), $urandom(), "init");
    for (int n = 0; n < 300; n++) begin
      r   = $urandom();
      a   = (r & 32'hFFFF_F003) | 32'(('h40 + $urandom_range(0, 15)) << 2);
      sel = $urandom_range(0, 19);
      if (sel < 8)       step(0, 1, 4'h0, a, $urandom(), "rnd_rd");
      else if (sel < 16) step(0, 1, legal_we[$urandom_range(0, 6)], a, $urandom(), "rnd_wr");
      else if (sel < 17) step(0, 1, bad_we[$urandom_range(0, 7)], a, $urandom(), "rnd_bad");
      else if (sel < 19) step(0, 0, 4'($urandom()), a, $urandom(), "rnd_idle");
      else               step(1, 1, 4'($urandom()), a, $urandom(), "rnd_rst");
    end

    step(0, 0, 4'h0, 32'h0, 32'h0, "drain");
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
